// File: rtl/clone_detect.sv
// ---------------------------------------------------------------------------
// clone_detect
//
// Purpose:
//   Tells a genuine console from a "new-type" famiclone by watching PPU reads.
//   After power-on the cartridge grounds CIRAM_CE and /A13 for INIT_CYCLES m2
//   cycles. It then samples a set of PPU reads with A13=0 and with A13=1. On
//   real hardware the console's inverted-A13 line is always the complement of
//   A13. If a sampled read shows them equal, that read counts as a mismatch.
//   Once enough mismatches are seen the block declares a clone. The verdict
//   can also be forced through `mode`.
//
// Ports:
//   m2           in   1  sole clock; every state update is on its rising edge
//   reset        in   1  synchronous, active-high reset
//   ppu_rd_in    in   1  PPU read strobe, active low
//   ppu_a13      in   1  PPU address bit 13
//   ppu_not_a13  in   1  console-side inverted A13 line
//   mode         in   2  00 auto, 01 force normal, 10 force clone,
//                        11 auto with timeout disabled
//   rearm        in   1  single-cycle pulse; restarts detection from OBSERVE
//   hold_low     out  1  high while CIRAM_CE and /A13 must be driven low
//   clone        out  1  famiclone detected or forced
//   done         out  1  high in DECIDED
//   state        out  2  00 INIT, 01 OBSERVE, 10 DECIDED
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module clone_detect #(
  parameter int INIT_CYCLES    = 15,
  parameter int LOW_SAMPLES    = 3,
  parameter int HIGH_SAMPLES   = 3,
  parameter int MISMATCH_MIN   = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       ppu_rd_in,
  input  logic       ppu_a13,
  input  logic       ppu_not_a13,
  input  logic [1:0] mode,
  input  logic       rearm,
  output logic       hold_low,
  output logic       clone,
  output logic       done,
  output logic [1:0] state
);

  localparam logic [1:0] ST_INIT    = 2'b00;
  localparam logic [1:0] ST_OBSERVE = 2'b01;
  localparam logic [1:0] ST_DECIDED = 2'b10;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_CLONE  = 2'b10;
  localparam logic [1:0] MODE_NO_TO  = 2'b11;

  localparam logic [15:0] INIT_LOAD    = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  LOW_LIMIT    = 8'(LOW_SAMPLES);
  localparam logic [7:0]  HIGH_LIMIT   = 8'(HIGH_SAMPLES);
  localparam logic [7:0]  MISMATCH_LIM = 8'(MISMATCH_MIN);

  // Registered outputs
  logic [1:0]  state_q,    state_d;
  logic        hold_low_q, hold_low_d;
  logic        clone_q,    clone_d;
  logic        done_q,     done_d;

  // Counters
  logic [15:0] init_cnt_q,    init_cnt_d;
  logic [15:0] timeout_cnt_q, timeout_cnt_d;
  logic [7:0]  low_cnt_q,     low_cnt_d;
  logic [7:0]  high_cnt_q,    high_cnt_d;
  logic [7:0]  mismatch_q,    mismatch_d;

  // Input sampling. The address lines are captured in the same stage as the
  // first read-strobe sample, so they describe the read being qualified.
  logic        rd_s1_q,  rd_s1_d;
  logic        rd_s2_q,  rd_s2_d;
  logic        a13_s_q,  a13_s_d;
  logic        na13_s_q, na13_s_d;

  // Per-cycle helper terms
  logic        qual_rd;
  logic        count_low;
  logic        count_high;
  logic        counted;
  logic        forced;
  logic        complete;
  logic        early_hit;
  logic        timed_out;

  // A falling edge is a low sample that follows a high sample. This allows at
  // most one qualified read per cycle.
  assign qual_rd = ~rd_s1_q & rd_s2_q;

  // A read is counted only while its class still needs samples. A read that is
  // not counted cannot add a mismatch.
  assign count_low  = qual_rd & ~a13_s_q & (low_cnt_q  < LOW_LIMIT);
  assign count_high = qual_rd &  a13_s_q & (high_cnt_q < HIGH_LIMIT);
  assign counted    = count_low | count_high;

  assign forced = (mode == MODE_NORMAL) || (mode == MODE_CLONE);

  always_comb begin
    // Default: hold every register.
    state_d       = state_q;
    clone_d       = clone_q;
    init_cnt_d    = init_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    low_cnt_d     = low_cnt_q;
    high_cnt_d    = high_cnt_q;
    mismatch_d    = mismatch_q;

    rd_s1_d  = ppu_rd_in;
    rd_s2_d  = rd_s1_q;
    a13_s_d  = ppu_a13;
    na13_s_d = ppu_not_a13;

    complete  = 1'b0;
    early_hit = 1'b0;
    timed_out = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == 16'd0) begin
          // A forced mode still runs the grounding phase.
          // It then skips observation.
          if (forced) begin
            state_d = ST_DECIDED;
            clone_d = (mode == MODE_CLONE);
          end else begin
            state_d = ST_OBSERVE;
          end
        end else begin
          init_cnt_d = init_cnt_q - 16'd1;
        end
      end

      ST_OBSERVE: begin
        if (rearm) begin
          state_d       = ST_OBSERVE;
          clone_d       = 1'b0;
          timeout_cnt_d = 16'd0;
          low_cnt_d     = 8'd0;
          high_cnt_d    = 8'd0;
          mismatch_d    = 8'd0;
        end else if (forced) begin
          state_d = ST_DECIDED;
          clone_d = (mode == MODE_CLONE);
        end else begin
          if (count_low) begin
            low_cnt_d = low_cnt_q + 8'd1;
          end
          if (count_high) begin
            high_cnt_d = high_cnt_q + 8'd1;
          end
          if (counted && (a13_s_q == na13_s_q) && (mismatch_q != 8'hFF)) begin
            mismatch_d = mismatch_q + 8'd1;
          end

          // Decisions use the next-state counters.
          // A read counted this cycle therefore takes part immediately.
          complete  = (low_cnt_d >= LOW_LIMIT) && (high_cnt_d >= HIGH_LIMIT);
          early_hit = (mismatch_d >= MISMATCH_LIM);
          timed_out = (mode != MODE_NO_TO) && (timeout_cnt_q >= TIMEOUT_LAST);

          // Priority: completion first, then an early mismatch verdict,
          // then the timeout.
          if (complete) begin
            state_d = ST_DECIDED;
            clone_d = early_hit;
          end else if (early_hit) begin
            state_d = ST_DECIDED;
            clone_d = 1'b1;
          end else if (timed_out) begin
            state_d = ST_DECIDED;
            clone_d = 1'b0;
          end else if (mode != MODE_NO_TO) begin
            timeout_cnt_d = timeout_cnt_q + 16'd1;
          end
        end
      end

      ST_DECIDED: begin
        if (rearm) begin
          state_d       = ST_OBSERVE;
          clone_d       = 1'b0;
          timeout_cnt_d = 16'd0;
          low_cnt_d     = 8'd0;
          high_cnt_d    = 8'd0;
          mismatch_d    = 8'd0;
        end else if (mode == MODE_NORMAL) begin
          clone_d = 1'b0;
        end else if (mode == MODE_CLONE) begin
          clone_d = 1'b1;
        end
        // Otherwise the verdict stays as it is until rearm or reset.
      end

      default: begin
        // Code 11 cannot be reached. If it appears anyway,
        // restart the power-on sequence cleanly.
        state_d       = ST_INIT;
        clone_d       = 1'b0;
        init_cnt_d    = INIT_LOAD;
        timeout_cnt_d = 16'd0;
        low_cnt_d     = 8'd0;
        high_cnt_d    = 8'd0;
        mismatch_d    = 8'd0;
      end
    endcase

    // hold_low depends on the state alone, so rearm can never raise it.
    hold_low_d = (state_d == ST_INIT);
    done_d     = (state_d == ST_DECIDED);
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      state_q       <= ST_INIT;
      hold_low_q    <= 1'b1;
      clone_q       <= 1'b0;
      done_q        <= 1'b0;
      init_cnt_q    <= INIT_LOAD;
      timeout_cnt_q <= 16'd0;
      low_cnt_q     <= 8'd0;
      high_cnt_q    <= 8'd0;
      mismatch_q    <= 8'd0;
      // Both strobe samples start high, so reset itself cannot create an edge.
      rd_s1_q       <= 1'b1;
      rd_s2_q       <= 1'b1;
      a13_s_q       <= 1'b0;
      na13_s_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      hold_low_q    <= hold_low_d;
      clone_q       <= clone_d;
      done_q        <= done_d;
      init_cnt_q    <= init_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      mismatch_q    <= mismatch_d;
      rd_s1_q       <= rd_s1_d;
      rd_s2_q       <= rd_s2_d;
      a13_s_q       <= a13_s_d;
      na13_s_q      <= na13_s_d;
    end
  end

  assign hold_low = hold_low_q;
  assign clone    = clone_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_clone_detect.sv
// ---------------------------------------------------------------------------
// tb_clone_detect
//
// Purpose:
//   Directed checks for clone_detect. The DUT runs with its default
//   parameters, except TIMEOUT_CYCLES, which is set to 100.
//   A table of read vectors covers the observation logic.
//   Hand-written sequences cover INIT, timeout, forced modes, and
//   reset/rearm interaction.
//   Inputs change on the falling edge of m2.
//   Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_clone_detect;

  logic       m2;
  logic       reset;
  logic       ppu_rd_in;
  logic       ppu_a13;
  logic       ppu_not_a13;
  logic [1:0] mode;
  logic       rearm;
  logic       hold_low;
  logic       clone;
  logic       done;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  clone_detect #(
    .INIT_CYCLES   (15),
    .LOW_SAMPLES   (3),
    .HIGH_SAMPLES  (3),
    .MISMATCH_MIN  (1),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .m2         (m2),
    .reset      (reset),
    .ppu_rd_in  (ppu_rd_in),
    .ppu_a13    (ppu_a13),
    .ppu_not_a13(ppu_not_a13),
    .mode       (mode),
    .rearm      (rearm),
    .hold_low   (hold_low),
    .clone      (clone),
    .done       (done),
    .state      (state)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  // Guard against a hang. The normal run ends long before this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    bit         rearm_first;
    bit         a13;
    bit         na13;
    bit         exp_done;
    bit         exp_clone;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(negedge m2);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int e_hold, input int e_clone,
                         input int e_done, input int e_state);
    chk({nm, ".hold_low"}, int'(hold_low), e_hold);
    chk({nm, ".clone"},    int'(clone),    e_clone);
    chk({nm, ".done"},     int'(done),     e_done);
    chk({nm, ".state"},    int'(state),    e_state);
  endtask

  // One PPU read: strobe low for a cycle, then high for a cycle.
  // Its effect is visible when the task returns.
  task automatic ppu_read(input bit a13, input bit na13);
    ppu_a13     = a13;
    ppu_not_a13 = na13;
    ppu_rd_in   = 1'b0;
    tick();
    ppu_rd_in   = 1'b1;
    tick();
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  initial begin
    // name, rearm_first, a13, na13, exp_done, exp_clone, exp_state
    vecs[0]  = '{"low1_ok",       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[1]  = '{"low2_ok",       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[2]  = '{"low3_ok",       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[3]  = '{"low_full_mm",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[4]  = '{"high1_ok",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[5]  = '{"high2_ok",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[6]  = '{"high3_done",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10};
    vecs[7]  = '{"early_mm",      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
    vecs[8]  = '{"after_early",   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10};
    vecs[9]  = '{"r_low1",        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[10] = '{"r_low2",        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[11] = '{"r_high1",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[12] = '{"r_high2",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[13] = '{"r_high3",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[14] = '{"last_low_mm",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10};

    reset       = 1'b1;
    ppu_rd_in   = 1'b1;
    ppu_a13     = 1'b0;
    ppu_not_a13 = 1'b1;
    mode        = 2'b00;
    rearm       = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_all("reset", 1, 0, 0, 0);
    $display("txn reset: hold_low=%0d state=%0d", hold_low, state);

    // INIT lasts exactly 15 cycles after reset is released.
    reset = 1'b0;
    repeat (14) tick();
    chk_all("init_cycle14", 1, 0, 0, 0);
    tick();
    chk_all("init_cycle15", 0, 0, 0, 1);
    $display("txn init: hold_low=%0d state=%0d", hold_low, state);

    // Read-vector table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rearm_first) pulse_rearm();
      ppu_read(vecs[i].a13, vecs[i].na13);
      chk_all(vecs[i].name, 0, int'(vecs[i].exp_clone),
              int'(vecs[i].exp_done), int'(vecs[i].exp_state));
      $display("txn vec%0d %s: a13=%0d na13=%0d -> done=%0d clone=%0d state=%0d",
               i, vecs[i].name, vecs[i].a13, vecs[i].na13, done, clone, state);
    end

    // Timeout: after rearm, with no reads, decide at OBSERVE cycle 100.
    pulse_rearm();
    chk_all("to_rearm", 0, 0, 0, 1);
    repeat (99) tick();
    chk_all("to_cycle99", 0, 0, 0, 1);
    tick();
    chk_all("to_cycle100", 0, 0, 1, 2);
    $display("txn timeout: done=%0d clone=%0d state=%0d", done, clone, state);

    // Mode 11 disables the timeout.
    mode = 2'b11;
    pulse_rearm();
    repeat (150) tick();
    chk_all("no_timeout", 0, 0, 0, 1);
    $display("txn mode11: done=%0d state=%0d", done, state);

    // Forced clone: reset mid-OBSERVE, INIT runs, then go straight to DECIDED.
    mode  = 2'b10;
    reset = 1'b1;
    tick();
    chk_all("force_reset", 1, 0, 0, 0);
    reset = 1'b0;
    repeat (14) tick();
    chk_all("force_init14", 1, 0, 0, 0);
    tick();
    chk_all("force_clone", 0, 1, 1, 2);
    $display("txn force10: clone=%0d done=%0d state=%0d", clone, done, state);

    // A mode change in DECIDED overrides the verdict on the next cycle.
    mode = 2'b01;
    tick();
    chk_all("force_normal", 0, 0, 1, 2);
    $display("txn force01: clone=%0d done=%0d", clone, done);

    // Rearm in auto mode returns to OBSERVE; hold_low stays low.
    mode = 2'b00;
    pulse_rearm();
    chk_all("rearm_auto", 0, 0, 0, 1);
    $display("txn rearm: done=%0d state=%0d hold_low=%0d", done, state, hold_low);

    // Reach DECIDED through a mismatch, then assert reset and rearm together.
    ppu_read(1'b1, 1'b1);
    chk_all("pre_rr_decided", 0, 1, 1, 2);
    reset = 1'b1;
    rearm = 1'b1;
    tick();
    chk_all("reset_rearm", 1, 0, 0, 0);
    $display("txn reset+rearm: hold_low=%0d state=%0d", hold_low, state);
    reset = 1'b0;
    rearm = 1'b0;
    repeat (15) tick();
    chk_all("rr_init_done", 0, 0, 0, 1);

    // With the counters cleared, one good read does not decide.
    ppu_read(1'b0, 1'b1);
    chk_all("rr_clean_read", 0, 0, 0, 1);
    $display("txn post-reset read: done=%0d state=%0d", done, state);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
